// File: rtl/alu_arbiter_pkg.sv
// Shared constants and types for the round-robin ALU arbiter.
// Mode encodings, the sequencer state set and the datapath width.
package alu_arbiter_pkg;

  localparam int ALU_W = 8;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bundle of the shared ALU: per-requester request, operands and mode,
// plus the arbiter's grant/done/result/flags returned to the requesters.
interface alu_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic [N-1:0]   req;
  logic [N*W-1:0] left;
  logic [N*W-1:0] right;
  logic [N*2-1:0] mode;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic [W-1:0]   result;
  logic           carry;
  logic           zero;
  logic           busy;

  modport master (
    output req, left, right, mode,
    input  grant, done, result, carry, zero, busy
  );

  modport slave (
    input  req, left, right, mode,
    output grant, done, result, carry, zero, busy
  );
endinterface

// File: rtl/alu_arbiter_alu8_core.sv
// Combinational 8-bit ALU shared by all requesters.
// carry is the add carry-out or the subtract borrow; logic modes clear it.
module alu8_core
  import alu_arbiter_pkg::*;
(
  input  logic [ALU_W-1:0] left,
  input  logic [ALU_W-1:0] right,
  input  logic [1:0]       mode,
  output logic [ALU_W-1:0] result,
  output logic             carry
);

  logic [ALU_W:0] wide_s;

  // Bit 8 of the 9-bit difference is set exactly when right > left (unsigned).
  always_comb begin
    wide_s = {(ALU_W+1){1'b0}};
    result = {ALU_W{1'b0}};
    carry  = 1'b0;
    case (mode)
      ALU_ADD: begin
        wide_s = {1'b0, left} + {1'b0, right};
        result = wide_s[ALU_W-1:0];
        carry  = wide_s[ALU_W];
      end
      ALU_SUB: begin
        wide_s = {1'b0, left} - {1'b0, right};
        result = wide_s[ALU_W-1:0];
        carry  = wide_s[ALU_W];
      end
      ALU_AND: result = left & right;
      ALU_OR:  result = left | right;
      default: begin
        result = {ALU_W{1'b0}};
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one alu8_core among N requesters:
// IDLE picks a winner and latches its operands, LOAD registers the ALU output, EXEC hands back done.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = ALU_W
) (
  input  logic clk,
  input  logic reset,
  alu_arbiter_if.slave bus
);

  localparam int PW = $clog2(N);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_LOAD = LOAD;
  localparam logic [1:0] ST_EXEC = EXEC;

  logic [1:0]    state_r;
  logic [PW-1:0] ptr_r;
  logic [PW-1:0] owner_r;
  logic [N-1:0]  grant_r;
  logic [N-1:0]  done_r;
  logic          busy_r;
  logic [W-1:0]  left_r;
  logic [W-1:0]  right_r;
  logic [1:0]    mode_r;
  logic [W-1:0]  result_r;
  logic          carry_r;
  logic          zero_r;

  logic [W-1:0]  left_a_s  [N];
  logic [W-1:0]  right_a_s [N];
  logic [1:0]    mode_a_s  [N];
  logic [PW:0]   sum_s;
  logic [PW-1:0] idx_s;
  logic [PW-1:0] win_s;
  logic          any_req_s;
  logic [W-1:0]  alu_result_s;
  logic          alu_carry_s;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign left_a_s[i]  = bus.left[i*W +: W];
    assign right_a_s[i] = bus.right[i*W +: W];
    assign mode_a_s[i]  = bus.mode[i*2 +: 2];
  end

  // Scan downward so the last hit kept is the nearest set bit at or above ptr (mod N).
  always_comb begin
    win_s     = {PW{1'b0}};
    any_req_s = 1'b0;
    sum_s     = {(PW+1){1'b0}};
    idx_s     = {PW{1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      sum_s     = {1'b0, ptr_r} + (PW+1)'(k);
      idx_s     = (sum_s >= (PW+1)'(N)) ? PW'(sum_s - (PW+1)'(N)) : sum_s[PW-1:0];
      any_req_s = any_req_s | bus.req[idx_s];
      win_s     = bus.req[idx_s] ? idx_s : win_s;
    end
  end

  alu8_core u_alu (
    .left   (left_r),
    .right  (right_r),
    .mode   (mode_r),
    .result (alu_result_s),
    .carry  (alu_carry_s)
  );

  // Sequencer, pointer, operand latches and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      ptr_r    <= {PW{1'b0}};
      owner_r  <= {PW{1'b0}};
      grant_r  <= {N{1'b0}};
      done_r   <= {N{1'b0}};
      busy_r   <= 1'b0;
      left_r   <= {W{1'b0}};
      right_r  <= {W{1'b0}};
      mode_r   <= 2'd0;
      result_r <= {W{1'b0}};
      carry_r  <= 1'b0;
      zero_r   <= 1'b1;
    end else begin
      done_r <= {N{1'b0}};
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            state_r <= ST_LOAD;
            busy_r  <= 1'b1;
            owner_r <= win_s;
            grant_r <= N'(1) << win_s;
            left_r  <= left_a_s[win_s];
            right_r <= right_a_s[win_s];
            mode_r  <= mode_a_s[win_s];
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          state_r  <= ST_EXEC;
          result_r <= alu_result_s;
          carry_r  <= alu_carry_s;
          zero_r   <= (alu_result_s == {W{1'b0}});
        end
        ST_EXEC: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= grant_r;
          grant_r <= {N{1'b0}};
          ptr_r   <= (owner_r == PW'(N - 1)) ? {PW{1'b0}} : owner_r + PW'(1);
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          grant_r <= {N{1'b0}};
        end
      endcase
    end
  end

  assign bus.grant  = grant_r;
  assign bus.done   = done_r;
  assign bus.busy   = busy_r;
  assign bus.result = result_r;
  assign bus.carry  = carry_r;
  assign bus.zero   = zero_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized traffic compared against a transaction-level reference model.
module tb_alu_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  alu_arbiter_if #(.N(4), .W(8)) bus ();

  alu_arbiter #(.N(4), .W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] l;
    logic [7:0] r;
    logic [1:0] m;
    logic [7:0] exp_res;
    logic       exp_c;
    logic       exp_z;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic [7:0] l, input logic [7:0] r, input logic [1:0] m);
    bus.left[i*8 +: 8]  = l;
    bus.right[i*8 +: 8] = r;
    bus.mode[i*2 +: 2]  = m;
  endtask

  function automatic logic [3:0] onehot(input int i);
    logic [3:0] v;
    v = 4'b0001 << i;
    return v;
  endfunction

  // Reference ALU from the arithmetic rules: {carry, result}.
  function automatic logic [8:0] ref_alu(input int l, input int r, input int m);
    int res;
    bit c;
    res = 0;
    c   = 1'b0;
    case (m)
      0: begin res = (l + r) % 256;       c = (l + r) > 255; end
      1: begin res = (l - r + 256) % 256; c = r > l;         end
      2: res = l & r;
      3: res = l | r;
      default: res = 0;
    endcase
    return {c, 8'(res)};
  endfunction

  // Reference round-robin pick: first requester at or above p, wrapping.
  function automatic int ref_pick(input logic [3:0] rq, input int p);
    for (int k = 0; k < 4; k++) begin
      if (rq[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic reset_dut();
    reset    = 1'b0;
    bus.req  = 4'b0000;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  // One isolated operation, checked through grant, result and done.
  task automatic do_op(input int w, input logic [7:0] l, input logic [7:0] r, input logic [1:0] m,
                       input logic [7:0] er, input logic ec, input logic ez);
    set_slot(w, l, r, m);
    bus.req[w] = 1'b1;
    tick();
    check("op_grant", 32'(bus.grant), 32'(onehot(w)));
    check("op_busy", 32'(bus.busy), 32'd1);
    check("op_done_early", 32'(bus.done), 32'd0);
    set_slot(w, ~l, ~r, ~m);
    tick();
    check("op_result", 32'(bus.result), 32'(er));
    check("op_carry", 32'(bus.carry), 32'(ec));
    check("op_zero", 32'(bus.zero), 32'(ez));
    tick();
    check("op_done", 32'(bus.done), 32'(onehot(w)));
    check("op_grant_clr", 32'(bus.grant), 32'd0);
    check("op_busy_clr", 32'(bus.busy), 32'd0);
    bus.req[w] = 1'b0;
    tick();
    check("op_done_pulse", 32'(bus.done), 32'd0);
  endtask

  logic [3:0] req_v;
  logic [7:0] lv [4];
  logic [7:0] rv [4];
  logic [1:0] mv [4];
  logic [8:0] expv;
  int         ptr;
  int         w;

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    bus.req   = 4'b0000;
    bus.left  = 32'h0;
    bus.right = 32'h0;
    bus.mode  = 8'h0;

    vecs[0] = '{2, 8'h05, 8'h03, 2'd0, 8'h08, 1'b0, 1'b0};
    vecs[1] = '{0, 8'hFF, 8'h01, 2'd0, 8'h00, 1'b1, 1'b1};
    vecs[2] = '{1, 8'h03, 8'h05, 2'd1, 8'hFE, 1'b1, 1'b0};
    vecs[3] = '{3, 8'hF0, 8'h3C, 2'd2, 8'h30, 1'b0, 1'b0};
    vecs[4] = '{2, 8'hA5, 8'h5A, 2'd3, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{1, 8'h77, 8'h77, 2'd1, 8'h00, 1'b0, 1'b1};
    vecs[6] = '{3, 8'h0F, 8'hF0, 2'd2, 8'h00, 1'b0, 1'b1};

    reset_dut();
    tick();
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.result), 32'h00);
    check("rst_carry", 32'(bus.carry), 32'd0);
    check("rst_zero", 32'(bus.zero), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("rst_busy", 32'(bus.busy), 32'd0);
      tick();
    end

    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].idx, vecs[i].l, vecs[i].r, vecs[i].m, vecs[i].exp_res, vecs[i].exp_c, vecs[i].exp_z);
    end

    // Contention: all four at once, served 0..3 back to back.
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      lv[i] = 8'(8'h10 * (i + 1));
      rv[i] = 8'(8'h07 + i);
      mv[i] = 2'(i);
      set_slot(i, lv[i], rv[i], mv[i]);
    end
    bus.req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("cont_grant", 32'(bus.grant), 32'(onehot(k)));
      check("cont_done_idle", 32'(bus.done), 32'd0);
      tick();
      expv = ref_alu(int'(lv[k]), int'(rv[k]), int'(mv[k]));
      check("cont_result", 32'(bus.result), 32'(expv[7:0]));
      tick();
      check("cont_done", 32'(bus.done), 32'(onehot(k)));
      bus.req[k] = 1'b0;
    end
    tick();

    // Fairness: req[0] permanent, req[1] reasserted after each of its done pulses.
    reset_dut();
    set_slot(0, 8'h01, 8'h01, 2'd0);
    set_slot(1, 8'h02, 8'h02, 2'd0);
    bus.req = 4'b0011;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("fair_grant", 32'(bus.grant), 32'(onehot(k % 2)));
      bus.req[1] = 1'b1;
      tick();
      tick();
      check("fair_done", 32'(bus.done), 32'(onehot(k % 2)));
      if ((k % 2) == 1) bus.req[1] = 1'b0;
    end
    bus.req = 4'b0000;
    tick();

    // Abort during EXEC after ptr has moved away from 0.
    reset_dut();
    do_op(1, 8'h01, 8'h02, 2'd0, 8'h03, 1'b0, 1'b0);
    set_slot(2, 8'h11, 8'h22, 2'd0);
    bus.req[2] = 1'b1;
    tick();
    check("abort_grant", 32'(bus.grant), 32'(onehot(2)));
    tick();
    reset   = 1'b0;
    bus.req = 4'b0000;
    tick();
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_grant_clr", 32'(bus.grant), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    reset = 1'b1;
    tick();
    check("abort_no_late_done", 32'(bus.done), 32'd0);
    set_slot(0, 8'h40, 8'h01, 2'd1);
    set_slot(3, 8'h20, 8'h0F, 2'd3);
    bus.req = 4'b1001;
    tick();
    check("abort_ptr_zero", 32'(bus.grant), 32'(onehot(0)));
    tick();
    tick();
    check("abort_done0", 32'(bus.done), 32'(onehot(0)));
    bus.req[0] = 1'b0;
    tick();
    check("abort_req3_grant", 32'(bus.grant), 32'(onehot(3)));
    tick();
    check("abort_req3_result", 32'(bus.result), 32'h2F);
    tick();
    check("abort_req3_done", 32'(bus.done), 32'(onehot(3)));
    bus.req = 4'b0000;
    tick();

    // Randomized traffic against the transaction model.
    reset_dut();
    ptr   = 0;
    req_v = 4'b0000;
    for (int op = 0; op < 60; op++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req_v[i] && $urandom_range(0, 2) == 0) begin
          req_v[i] = 1'b1;
          lv[i] = 8'($urandom_range(0, 255));
          rv[i] = 8'($urandom_range(0, 255));
          mv[i] = 2'($urandom_range(0, 3));
          set_slot(i, lv[i], rv[i], mv[i]);
        end
      end
      bus.req = req_v;
      if (req_v == 4'b0000) begin
        tick();
        check("rnd_idle_grant", 32'(bus.grant), 32'd0);
        check("rnd_idle_busy", 32'(bus.busy), 32'd0);
        continue;
      end
      w    = ref_pick(req_v, ptr);
      expv = ref_alu(int'(lv[w]), int'(rv[w]), int'(mv[w]));
      tick();
      check("rnd_grant", 32'(bus.grant), 32'(onehot(w)));
      check("rnd_busy", 32'(bus.busy), 32'd1);
      if ($urandom_range(0, 1) == 1) begin
        set_slot(w, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
      end
      if ($urandom_range(0, 3) == 0) begin
        req_v[w] = 1'b0;
        bus.req  = req_v;
      end
      tick();
      check("rnd_result", 32'(bus.result), 32'(expv[7:0]));
      check("rnd_carry", 32'(bus.carry), 32'(expv[8]));
      check("rnd_zero", 32'(bus.zero), 32'(expv[7:0] == 8'h00));
      tick();
      check("rnd_done", 32'(bus.done), 32'(onehot(w)));
      check("rnd_grant_clr", 32'(bus.grant), 32'd0);
      ptr = (w + 1) % 4;
      if ($urandom_range(0, 1) == 1) begin
        req_v[w] = 1'b1;
        lv[w] = 8'($urandom_range(0, 255));
        rv[w] = 8'($urandom_range(0, 255));
        mv[w] = 2'($urandom_range(0, 3));
        set_slot(w, lv[w], rv[w], mv[w]);
      end else begin
        req_v[w] = 1'b0;
      end
      bus.req = req_v;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
